// File: rtl/ddr3_pkg.sv
// Shared definitions for the DDR3 command scheduler: sequencer command
// encodings ({cs_n, ras_n, cas_n, we_n}), address constants and FSM states.
package ddr3_pkg;

    localparam logic [3:0] CMD_NOP       = 4'b0111;
    localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
    localparam logic [3:0] CMD_READ      = 4'b0101;
    localparam logic [3:0] CMD_WRITE     = 4'b0100;
    localparam logic [3:0] CMD_ZQCL      = 4'b0110;
    localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
    localparam logic [3:0] CMD_REFRESH   = 4'b0001;
    localparam logic [3:0] CMD_LOAD_MODE = 4'b0000;

    // A10 selects all-bank precharge / long ZQ calibration / auto-precharge
    localparam logic [14:0] ADDR_A10 = 15'h0400;

    typedef enum logic [3:0] {
        ST_INIT_WAIT,
        ST_CKE_WAIT,
        ST_MR2,
        ST_MR3,
        ST_MR1,
        ST_MR0,
        ST_ZQCL,
        ST_IDLE,
        ST_PRECHARGE,
        ST_ACTIVATE,
        ST_RDWR,
        ST_PREALL,
        ST_REFRESH
    } state_t;

endpackage

// File: rtl/ddr3_bank_tracker.sv
// Per-bank open-row bookkeeping: one open flag and one row register per bank,
// with a combinational hit/open lookup on the addressed bank.
module ddr3_bank_tracker #(
    parameter int BANK_W = 3,
    parameter int ROW_W  = 15
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [BANK_W-1:0] bank,
    input  logic [ROW_W-1:0]  row,
    input  logic              set_open,
    input  logic              clear_one,
    input  logic              clear_all,
    output logic              is_open,
    output logic              is_hit,
    output logic              any_open
);

    localparam int NUM_BANKS = 1 << BANK_W;

    logic [NUM_BANKS-1:0] open_vec;
    logic [ROW_W-1:0]     row_vec [NUM_BANKS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
            logic             open_reg;
            logic [ROW_W-1:0] row_reg;
            logic             sel;

            assign sel = (bank == BANK_W'(gi));

            // Open on ACTIVATE of this bank; close on its PRECHARGE or on PREALL
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    open_reg <= 1'b0;
                    row_reg  <= '0;
                end else if (clear_all || (clear_one && sel)) begin
                    open_reg <= 1'b0;
                end else if (set_open && sel) begin
                    open_reg <= 1'b1;
                    row_reg  <= row;
                end
            end

            assign open_vec[gi] = open_reg;
            assign row_vec[gi]  = row_reg;
        end
    endgenerate

    assign is_open  = open_vec[bank];
    assign is_hit   = is_open && (row_vec[bank] == row);
    assign any_open = |open_vec;

endmodule

// File: rtl/ddr3_cmd_sched.sv
// DDR3 command scheduler: power-up/mode-register init, periodic refresh and
// open-page ACTIVATE/READ/WRITE/PRECHARGE ordering toward the DFI sequencer.
// Timing is enforced downstream through seq_accept_i.
// Define DDR3_CMD_SCHED_CLOSE_PAGE_EN for auto-precharge (close-page) operation.
module ddr3_cmd_sched
    import ddr3_pkg::*;
#(
    parameter int          DDR_MHZ         = 50,
    parameter int          DDR_INIT_CYCLES = 25000,
    parameter int          DDR_COL_W       = 9,
    parameter int          DDR_BANK_W      = 3,
    parameter int          DDR_ROW_W       = 15,
    parameter logic [14:0] DDR_MR0         = 15'h0120,
    parameter logic [14:0] DDR_MR1         = 15'h0006,
    parameter logic [14:0] DDR_MR2         = 15'h0008,
    parameter logic [14:0] DDR_MR3         = 15'h0000
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    input  logic                  req_write_i,
    input  logic [31:0]           req_addr_i,
    input  logic [127:0]          req_wrdata_i,
    input  logic [15:0]           req_wrmask_i,
    output logic                  req_accept_o,
    output logic                  resp_valid_o,
    output logic [127:0]          resp_rddata_o,
    output logic                  busy_o,
    output logic [3:0]            seq_command_o,
    output logic [14:0]           seq_address_o,
    output logic [DDR_BANK_W-1:0] seq_bank_o,
    output logic                  seq_cke_o,
    output logic [127:0]          seq_wrdata_o,
    output logic [15:0]           seq_wrmask_o,
    input  logic                  seq_accept_i,
    input  logic [127:0]          seq_rddata_i,
    input  logic                  seq_rddata_valid_i
);

    localparam int TREFI_CYCLES = DDR_MHZ * 78 / 10;
    localparam int ADDR_TOP     = DDR_COL_W + 1 + DDR_BANK_W + DDR_ROW_W;

`ifdef DDR3_CMD_SCHED_CLOSE_PAGE_EN
    localparam logic [14:0] RDWR_FLAGS = ADDR_A10;
`else
    localparam logic [14:0] RDWR_FLAGS = 15'h0000;
`endif

    state_t                  state_reg, state_next;
    logic [31:0]             init_cnt_reg, init_cnt_next;
    logic                    cke_reg, cke_next;
    logic                    init_done_reg, init_done_next;
    logic [3:0]              cmd_reg, cmd_next;
    logic [14:0]             addr_reg, addr_next;
    logic [DDR_BANK_W-1:0]   bank_reg, bank_next;
    logic [127:0]            wrdata_reg;
    logic [15:0]             wrmask_reg;
    logic [31:0]             refi_cnt_reg;
    logic                    refresh_pending_reg;
    logic [3:0]              rd_cnt_reg;
    logic                    resp_valid_reg;
    logic [127:0]            resp_data_reg;

    logic                    cmd_accepted, wr_load, rd_issue, refresh_done, rd_stall;
    logic                    trk_set, trk_clear_one, trk_clear_all;
    logic                    trk_open, trk_hit, trk_any_open;
    logic [DDR_BANK_W-1:0]   req_bank;
    logic [DDR_ROW_W-1:0]    req_row;
    logic [14:0]             col_addr;
    logic [3:0]              rdwr_cmd;
    logic                    unused_addr;

    assign req_bank     = req_addr_i[DDR_COL_W+1 +: DDR_BANK_W];
    assign req_row      = req_addr_i[DDR_COL_W+1+DDR_BANK_W +: DDR_ROW_W];
    assign col_addr     = 15'({req_addr_i[DDR_COL_W:4], 3'b000}) | RDWR_FLAGS;
    assign rdwr_cmd     = req_write_i ? CMD_WRITE : CMD_READ;
    assign unused_addr  = ^{req_addr_i[3:0], req_addr_i[31:ADDR_TOP]};
    assign cmd_accepted = (cmd_reg != CMD_NOP) && seq_accept_i;
    assign rd_stall     = !req_write_i && (rd_cnt_reg == 4'hF);

    ddr3_bank_tracker #(
        .BANK_W (DDR_BANK_W),
        .ROW_W  (DDR_ROW_W)
    ) u_tracker (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .bank      (req_bank),
        .row       (req_row),
        .set_open  (trk_set),
        .clear_one (trk_clear_one),
        .clear_all (trk_clear_all),
        .is_open   (trk_open),
        .is_hit    (trk_hit),
        .any_open  (trk_any_open)
    );

`ifdef DDR3_CMD_SCHED_CLOSE_PAGE_EN
    logic unused_trk;
    assign unused_trk = trk_open ^ trk_hit ^ trk_any_open;
`endif

    // Next state and next command; a command register is only replaced on a transition
    always_comb begin
        state_next     = state_reg;
        cmd_next       = cmd_accepted ? CMD_NOP : cmd_reg;
        addr_next      = addr_reg;
        bank_next      = bank_reg;
        cke_next       = cke_reg;
        init_cnt_next  = '0;
        init_done_next = init_done_reg;
        wr_load        = 1'b0;
        rd_issue       = 1'b0;
        refresh_done   = 1'b0;
        trk_set        = 1'b0;
        trk_clear_one  = 1'b0;
        trk_clear_all  = 1'b0;
        case (state_reg)
            ST_INIT_WAIT: begin
                cke_next      = 1'b0;
                init_cnt_next = init_cnt_reg + 32'd1;
                if (init_cnt_reg == 32'(DDR_INIT_CYCLES - 1)) begin
                    state_next    = ST_CKE_WAIT;
                    cke_next      = 1'b1;
                    init_cnt_next = '0;
                end
            end
            ST_CKE_WAIT: begin
                init_cnt_next = init_cnt_reg + 32'd1;
                if (init_cnt_reg == 32'(DDR_INIT_CYCLES / 2 - 1)) begin
                    state_next = ST_MR2;
                    cmd_next   = CMD_LOAD_MODE;
                    bank_next  = DDR_BANK_W'(2);
                    addr_next  = DDR_MR2;
                end
            end
            ST_MR2: if (cmd_accepted) begin
                state_next = ST_MR3;
                cmd_next   = CMD_LOAD_MODE;
                bank_next  = DDR_BANK_W'(3);
                addr_next  = DDR_MR3;
            end
            ST_MR3: if (cmd_accepted) begin
                state_next = ST_MR1;
                cmd_next   = CMD_LOAD_MODE;
                bank_next  = DDR_BANK_W'(1);
                addr_next  = DDR_MR1;
            end
            ST_MR1: if (cmd_accepted) begin
                state_next = ST_MR0;
                cmd_next   = CMD_LOAD_MODE;
                bank_next  = DDR_BANK_W'(0);
                addr_next  = DDR_MR0;
            end
            ST_MR0: if (cmd_accepted) begin
                state_next = ST_ZQCL;
                cmd_next   = CMD_ZQCL;
                bank_next  = '0;
                addr_next  = ADDR_A10;
            end
            ST_ZQCL: if (cmd_accepted) begin
                state_next     = ST_IDLE;
                init_done_next = 1'b1;
            end
            ST_IDLE: begin
                if (refresh_pending_reg) begin
                    bank_next = '0;
`ifdef DDR3_CMD_SCHED_CLOSE_PAGE_EN
                    state_next = ST_REFRESH;
                    cmd_next   = CMD_REFRESH;
                    addr_next  = '0;
`else
                    if (trk_any_open) begin
                        state_next = ST_PREALL;
                        cmd_next   = CMD_PRECHARGE;
                        addr_next  = ADDR_A10;
                    end else begin
                        state_next = ST_REFRESH;
                        cmd_next   = CMD_REFRESH;
                        addr_next  = '0;
                    end
`endif
                end else if (req_valid_i && !rd_stall) begin
                    bank_next = req_bank;
`ifdef DDR3_CMD_SCHED_CLOSE_PAGE_EN
                    state_next = ST_ACTIVATE;
                    cmd_next   = CMD_ACTIVE;
                    addr_next  = 15'(req_row);
`else
                    if (trk_hit) begin
                        state_next = ST_RDWR;
                        cmd_next   = rdwr_cmd;
                        addr_next  = col_addr;
                        wr_load    = req_write_i;
                    end else if (trk_open) begin
                        state_next = ST_PRECHARGE;
                        cmd_next   = CMD_PRECHARGE;
                        addr_next  = '0;
                    end else begin
                        state_next = ST_ACTIVATE;
                        cmd_next   = CMD_ACTIVE;
                        addr_next  = 15'(req_row);
                    end
`endif
                end
            end
            ST_PRECHARGE: if (cmd_accepted) begin
                trk_clear_one = 1'b1;
                state_next    = ST_ACTIVATE;
                cmd_next      = CMD_ACTIVE;
                addr_next     = 15'(req_row);
            end
            ST_ACTIVATE: if (cmd_accepted) begin
`ifndef DDR3_CMD_SCHED_CLOSE_PAGE_EN
                trk_set    = 1'b1;
`endif
                state_next = ST_RDWR;
                cmd_next   = rdwr_cmd;
                addr_next  = col_addr;
                wr_load    = req_write_i;
            end
            ST_RDWR: if (cmd_accepted) begin
                rd_issue   = !req_write_i;
                state_next = ST_IDLE;
            end
            ST_PREALL: if (cmd_accepted) begin
                trk_clear_all = 1'b1;
                state_next    = ST_REFRESH;
                cmd_next      = CMD_REFRESH;
                addr_next     = '0;
            end
            ST_REFRESH: if (cmd_accepted) begin
                refresh_done = 1'b1;
                state_next   = ST_IDLE;
            end
            default: state_next = ST_INIT_WAIT;
        endcase
    end

    // FSM, init counter and registered command/address/bank outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg     <= ST_INIT_WAIT;
            init_cnt_reg  <= '0;
            cke_reg       <= 1'b0;
            init_done_reg <= 1'b0;
            cmd_reg       <= CMD_NOP;
            addr_reg      <= '0;
            bank_reg      <= '0;
        end else begin
            state_reg     <= state_next;
            init_cnt_reg  <= init_cnt_next;
            cke_reg       <= cke_next;
            init_done_reg <= init_done_next;
            cmd_reg       <= cmd_next;
            addr_reg      <= addr_next;
            bank_reg      <= bank_next;
        end
    end

    // Write data and DM captured alongside the WRITE command, held until accepted
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wrdata_reg <= '0;
            wrmask_reg <= '0;
        end else if (wr_load) begin
            wrdata_reg <= req_wrdata_i;
            wrmask_reg <= ~req_wrmask_i;
        end
    end

    // Refresh interval timer runs once init is done; pending survives extra wraps
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            refi_cnt_reg        <= '0;
            refresh_pending_reg <= 1'b0;
        end else begin
            if (refresh_done)
                refresh_pending_reg <= 1'b0;
            if (init_done_reg) begin
                if (refi_cnt_reg == 32'(TREFI_CYCLES - 1)) begin
                    refi_cnt_reg        <= '0;
                    refresh_pending_reg <= 1'b1;
                end else begin
                    refi_cnt_reg <= refi_cnt_reg + 32'd1;
                end
            end
        end
    end

    // Outstanding reads and the one-cycle registered response path
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_cnt_reg     <= '0;
            resp_valid_reg <= 1'b0;
            resp_data_reg  <= '0;
        end else begin
            if (rd_issue && !seq_rddata_valid_i)
                rd_cnt_reg <= rd_cnt_reg + 4'd1;
            else if (!rd_issue && seq_rddata_valid_i)
                rd_cnt_reg <= rd_cnt_reg - 4'd1;
            resp_valid_reg <= seq_rddata_valid_i;
            resp_data_reg  <= seq_rddata_i;
        end
    end

    assign req_accept_o  = (state_reg == ST_RDWR) && seq_accept_i;
    assign busy_o        = !init_done_reg || refresh_pending_reg || (rd_cnt_reg != 4'd0);
    assign resp_valid_o  = resp_valid_reg;
    assign resp_rddata_o = resp_data_reg;
    assign seq_command_o = cmd_reg;
    assign seq_address_o = addr_reg;
    assign seq_bank_o    = bank_reg;
    assign seq_cke_o     = cke_reg;
    assign seq_wrdata_o  = wrdata_reg;
    assign seq_wrmask_o  = wrmask_reg;

endmodule
